operand2_sequencer: RTL and testbench
=====================================

# operand2_sequencer

Front end of the data-processing operand-2 path. Accepts a 12-bit operand-2 field, the I bit and the Rm value, fetches Rs through a register-file read port for register-specified shifts, and resolves every ARM shift-amount case. A single 5-bit-amount shifter cannot cover all of these cases, which include amounts of 0, 32, more than 32, and rotated immediates. It returns the operand-2 word and the shifter carry-out to the ALU over a valid/ready handshake.

## Interface
- WORD_W, 32, datapath width (fixed at 32).
- in_Clk  in  1  clock; all state changes on the rising edge.
- in_Rst_N  in  1  asynchronous, active-low reset.
- in_Valid  in  1  request valid.
- out_Ready  out  1  request accepted when in_Valid && out_Ready; reset 1.
- in_I  in  1  1 = rotated immediate form.
- in_Operand2  in  12  instruction bits [11:0].
- in_Rm_val  in  32  Rm contents, sampled at accept.
- in_C_flag  in  1  CPSR C, sampled at accept.
- out_Rs_req  out  1  Rs read strobe, one-cycle pulse; reset 0.
- out_Rs_addr  out  4  Rs index (Operand2[11:8]); reset 0.
- in_Rs_val  in  32  Rs contents, valid the cycle after out_Rs_req.
- out_Valid  out  1  result valid; reset 0.
- in_Ready  in  1  consumer ready.
- out_Op2  out  32  operand 2; reset 0.
- out_Carry  out  1  shifter carry-out; reset 0.
- out_Illegal  out  1  qualifies out_Valid; encoding not a valid operand 2; reset 0.

## Operation
- FSM states: IDLE, RS_REQ, RS_CAP, RESULT. The reset state is IDLE.
- out_Ready = (state == IDLE).
- **IDLE, on accept:** latch all inputs.
  - Register-shift form (I=0, bit4=1, bit7=0): go to RS_REQ.
  - All other forms: compute and go to RESULT.
- **RS_REQ:** assert out_Rs_req and out_Rs_addr, then go to RS_CAP.
- **RS_CAP:** capture in_Rs_val[7:0] as amt, compute, then go to RESULT.
- **RESULT:** out_Valid=1; out_Op2, out_Carry and out_Illegal are held stable. Go to IDLE when in_Ready=1.
- **Immediate form:** op2 = ROR(imm8, 2*rot4).
  - rot4=0: op2 = imm8, carry = C. This must never be treated as RRX.
  - Otherwise: carry = op2[31].
- **Immediate-shift form:** imm5, type and Rm go to the shifter unchanged. This gives LSL #0 = passthrough, LSR/ASR #0 = shift by 32, and ROR #0 = RRX.
- **Register-shift form, by amt:**
  - amt = 0: op2 = Rm, carry = C.
  - 1 ≤ amt ≤ 31: shifter result.
  - amt = 32:
    - LSL: op2 = 0, carry = Rm[0].
    - LSR: op2 = 0, carry = Rm[31].
    - ASR: op2 = {32{Rm[31]}}, carry = Rm[31].
    - ROR: op2 = Rm, carry = Rm[31].
  - amt > 32:
    - LSL/LSR: op2 = 0, carry = 0.
    - ASR: same as the 32 case.
    - ROR with amt[4:0] = 0: op2 = Rm, carry = Rm[31].
    - ROR otherwise: ROR by amt[4:0].
- **Illegal encoding (I=0, bit4=1, bit7=1):** go straight to RESULT with op2 = 0, carry = C, out_Illegal = 1. No Rs request is issued.

## Timing
- Immediate, immediate-shift and illegal forms: out_Valid is high on the cycle after accept.
- Register-shift form:
  - out_Rs_req is high the cycle after accept.
  - in_Rs_val is sampled one cycle later.
  - out_Valid is high 3 cycles after accept.
- Throughput: at most one request in flight. The next accept is no earlier than the cycle after the RESULT handshake.
- Backpressure: RESULT holds indefinitely and outputs do not change.
- Reset asserted in any state:
  - Outputs go to their reset values immediately (asynchronous reset).
  - The in-flight request is dropped; no partial result is ever presented.
- in_Rm_val, in_C_flag and in_Rs_val are don't-care outside their sampling cycles.

## Configuration
- OP2SEQ_REG_SHIFT_EN defined: full behaviour as above.
- OP2SEQ_REG_SHIFT_EN undefined:
  - RS_REQ and RS_CAP are not built.
  - out_Rs_req and out_Rs_addr are tied to 0.
  - Register-shift forms take the illegal path: 1-cycle latency, op2 = 0, carry = C, out_Illegal = 1.

## Structure
- The shared definitions package holds:
  - WordWidth.
  - Shift-type codes: LSL=00, LSR=01, ASR=10, ROR=11.
  - FSM state encodings.
  - Operand-2 field bit positions (rot [11:8], imm8 [7:0], imm5 [11:7], type [6:5], Rs [11:8], Rm [3:0]).
- Sub-module: one instance of the existing `barrel_shifter` (5-bit amount), with its inputs muxed. The immediate form uses ROR by {rot4,0}. The bypass cases (rot4=0, amt=0, amt ≥ 32) are resolved outside it.

## Test plan
- Immediate: I=1, Operand2=0x4FF, C=0 -> op2=0xFF000000, carry=1, out_Valid 1 cycle after accept. Operand2=0x0FF, C=1 -> op2=0x000000FF, carry=1.
- Immediate shift, LSR #0: Operand2=0x020, Rm=0x80000001 -> op2=0, carry=1. ROR #0 (RRX): Operand2=0x060, Rm=0x00000003, C=1 -> op2=0x80000001, carry=1.
- Register LSL, Rs=32: Operand2=0x310, Rm=0x00000003 -> out_Rs_req pulse with addr=3, op2=0, carry=1, out_Valid 3 cycles after accept. Rs=33 -> op2=0, carry=0.
- Register ROR with Rm=0x80000000, C=0:
  - Rs=0x40 -> op2=0x80000000, carry=1.
  - Rs=0x100 (amt=0) -> op2=Rm, carry=0.
  - Rs=0x24 -> op2=0x08000000, carry=0.
- Backpressure and reset:
  - Hold in_Ready=0 for 5 cycles in RESULT -> out_Valid, out_Op2 and out_Carry stable; out_Ready=0.
  - Assert in_Rst_N=0 during RS_REQ -> all outputs at reset values; no result after release.
- Illegal: Operand2=0x090, C=1 -> out_Illegal=1, op2=0, carry=1, no out_Rs_req. With OP2SEQ_REG_SHIFT_EN undefined, Operand2=0x310 gives the same response.

Source files
------------

// File: rtl/operand2_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// operand2_sequencer_pkg
//   Shared definitions for the operand-2 front end: datapath width, shifter
//   type codes, sequencer FSM states, operand-2 field positions and the
//   encoding-class decoders used by the sequencer.
// -----------------------------------------------------------------------------
package operand2_sequencer_pkg;

   localparam int unsigned WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_type_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RS_REQ = 2'd1,
      ST_RS_CAP = 2'd2,
      ST_RESULT = 2'd3
   } state_e;

   // Operand-2 field positions within instruction bits [11:0].
   localparam int ROT_MSB   = 11;
   localparam int ROT_LSB   = 8;
   localparam int IMM8_MSB  = 7;
   localparam int IMM8_LSB  = 0;
   localparam int IMM5_MSB  = 11;
   localparam int IMM5_LSB  = 7;
   localparam int TYPE_MSB  = 6;
   localparam int TYPE_LSB  = 5;
   localparam int RS_MSB    = 11;
   localparam int RS_LSB    = 8;
   localparam int RM_MSB    = 3;
   localparam int RM_LSB    = 0;
   localparam int REG_BIT   = 4;   // 1 = shift amount comes from Rs
   localparam int ILLEG_BIT = 7;   // must be 0 when REG_BIT is set

   // Register-specified shift: I=0, bit4=1, bit7=0.
   function automatic logic is_reg_shift(input logic i, input logic [11:0] op2);
      return !i && op2[REG_BIT] && !op2[ILLEG_BIT];
   endfunction

   // Not a data-processing operand 2 (multiply / extension space).
   function automatic logic is_illegal(input logic i, input logic [11:0] op2);
      return !i && op2[REG_BIT] && op2[ILLEG_BIT];
   endfunction

endpackage

// File: rtl/barrel_shifter.sv
// -----------------------------------------------------------------------------
// barrel_shifter
//   Single-cycle ARM shifter with a 5-bit amount and immediate-shift
//   semantics for amount 0: LSL #0 passes through with carry_i, LSR/ASR #0
//   shift by 32, ROR #0 is RRX.
//   Ports:
//     data_i   [31:0]  value to shift
//     amt_i    [4:0]   shift amount
//     type_i           shift type (LSL/LSR/ASR/ROR)
//     carry_i          incoming C flag (LSL #0 and RRX)
//     result_o [31:0]  shifted value
//     carry_o          shifter carry-out
// -----------------------------------------------------------------------------
module barrel_shifter
   import operand2_sequencer_pkg::*;
(
   input  logic                  [WORD_WIDTH-1:0] data_i,
   input  logic                  [4:0]            amt_i,
   input  shift_type_e                            type_i,
   input  logic                                   carry_i,
   output logic                  [WORD_WIDTH-1:0] result_o,
   output logic                                   carry_o
);

   logic        [5:0]          eff_amt;   // 0 encodes 32 for LSR/ASR
   logic        [WORD_WIDTH:0] lsl_ext;   // {carry, result}
   logic        [WORD_WIDTH:0] lsr_ext;   // {result, carry}
   logic signed [WORD_WIDTH:0] asr_ext;   // {result, carry}
   logic        [WORD_WIDTH-1:0] ror_res;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      result_o = data_i;
      carry_o  = carry_i;

      eff_amt = (amt_i == 5'd0) ? 6'd32 : {1'b0, amt_i};
      lsl_ext = {1'b0, data_i} << amt_i;
      lsr_ext = {data_i, 1'b0} >> eff_amt;
      asr_ext = $signed({data_i, 1'b0}) >>> eff_amt;
      ror_res = (data_i >> amt_i) | (data_i << (6'd32 - eff_amt));

      unique case (type_i)
         SH_LSL: begin
            if (amt_i != 5'd0) begin
               result_o = lsl_ext[WORD_WIDTH-1:0];
               carry_o  = lsl_ext[WORD_WIDTH];
            end
         end
         SH_LSR: begin
            result_o = lsr_ext[WORD_WIDTH:1];
            carry_o  = lsr_ext[0];
         end
         SH_ASR: begin
            result_o = asr_ext[WORD_WIDTH:1];
            carry_o  = asr_ext[0];
         end
         SH_ROR: begin
            if (amt_i == 5'd0) begin
               result_o = {carry_i, data_i[WORD_WIDTH-1:1]};
               carry_o  = data_i[0];
            end else begin
               result_o = ror_res;
               carry_o  = ror_res[WORD_WIDTH-1];
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/operand2_sequencer.sv
// -----------------------------------------------------------------------------
// operand2_sequencer
//   Operand-2 front end: accepts the 12-bit operand-2 field, I bit and Rm,
//   fetches Rs for register-specified shifts, resolves every ARM shift-amount
//   case around a single 5-bit barrel shifter, and hands op2 + carry-out to
//   the ALU over valid/ready.
//   Build option: OP2SEQ_REG_SHIFT_EN enables register-specified shifts;
//   without it they are reported as illegal and no Rs port activity occurs.
//   Ports:
//     in_Clk, in_Rst_N          clock, async active-low reset
//     in_Valid / out_Ready      request handshake (ready only in IDLE)
//     in_I, in_Operand2         encoding form and operand-2 field
//     in_Rm_val, in_C_flag      Rm and C, sampled at accept
//     out_Rs_req, out_Rs_addr   Rs read strobe and index
//     in_Rs_val                 Rs data, valid the cycle after out_Rs_req
//     out_Valid / in_Ready      result handshake
//     out_Op2, out_Carry        operand 2 and shifter carry-out
//     out_Illegal               qualifies out_Valid: bad operand-2 encoding
// -----------------------------------------------------------------------------
module operand2_sequencer
   import operand2_sequencer_pkg::*;
#(
   parameter int unsigned WORD_W = WORD_WIDTH
)(
   input  logic              in_Clk,
   input  logic              in_Rst_N,
   input  logic              in_Valid,
   output logic              out_Ready,
   input  logic              in_I,
   input  logic [11:0]       in_Operand2,
   input  logic [WORD_W-1:0] in_Rm_val,
   input  logic              in_C_flag,
   output logic              out_Rs_req,
   output logic [3:0]        out_Rs_addr,
   input  logic [WORD_W-1:0] in_Rs_val,
   output logic              out_Valid,
   input  logic              in_Ready,
   output logic [WORD_W-1:0] out_Op2,
   output logic              out_Carry,
   output logic              out_Illegal
);

   state_e            state_q, state_d;
   logic [WORD_W-1:0] op2_q, op2_d;
   logic              carry_q, carry_d;
   logic              illegal_q, illegal_d;

   // Operands feeding the result logic: live inputs in IDLE, latched copies
   // while waiting for Rs.
   logic              src_i;
   logic [11:0]       src_op2;
   logic [WORD_W-1:0] src_rm;
   logic              src_c;
   logic              take_rs_path;

   // Shifter hookup and the fully resolved result.
   logic [WORD_W-1:0] sh_data, sh_result;
   logic [4:0]        sh_amt;
   shift_type_e       sh_type;
   logic              sh_cin, sh_carry;
   logic [WORD_W-1:0] res_op2;
   logic              res_carry, res_illegal;

`ifdef OP2SEQ_REG_SHIFT_EN
   logic [11:0]       fld_q;
   logic [WORD_W-1:0] rm_q;
   logic              c_q;
   logic [7:0]        amt;
   logic              unused_rs_hi;

   always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      if (!in_Rst_N) begin
         fld_q <= '0;
         rm_q  <= '0;
         c_q   <= 1'b0;
      end else if (state_q == ST_IDLE && in_Valid) begin
         fld_q <= in_Operand2;
         rm_q  <= in_Rm_val;
         c_q   <= in_C_flag;
      end
   end

   assign src_i        = (state_q == ST_IDLE) ? in_I        : 1'b0;
   assign src_op2      = (state_q == ST_IDLE) ? in_Operand2 : fld_q;
   assign src_rm       = (state_q == ST_IDLE) ? in_Rm_val   : rm_q;
   assign src_c        = (state_q == ST_IDLE) ? in_C_flag   : c_q;
   assign take_rs_path = is_reg_shift(in_I, in_Operand2);
   // Only the bottom byte of Rs is a shift amount.
   assign amt          = in_Rs_val[7:0];
   assign unused_rs_hi = ^in_Rs_val[WORD_W-1:8];
`else
   logic unused_rs;

   assign src_i        = in_I;
   assign src_op2      = in_Operand2;
   assign src_rm       = in_Rm_val;
   assign src_c        = in_C_flag;
   assign take_rs_path = 1'b0;
   assign unused_rs    = ^in_Rs_val;
`endif

   barrel_shifter u_shifter (
      .data_i   (sh_data),
      .amt_i    (sh_amt),
      .type_i   (sh_type),
      .carry_i  (sh_cin),
      .result_o (sh_result),
      .carry_o  (sh_carry)
   );

   // Result resolution. Defaults describe the immediate-shift form, which
   // uses the shifter's own amount-0 semantics unchanged.
   always_comb begin
      sh_data     = src_rm;
      sh_amt      = src_op2[IMM5_MSB:IMM5_LSB];
      sh_type     = shift_type_e'(src_op2[TYPE_MSB:TYPE_LSB]);
      sh_cin      = src_c;
      res_op2     = sh_result;
      res_carry   = sh_carry;
      res_illegal = 1'b0;

      if (src_i) begin
         // Rotated immediate; rot4 = 0 must bypass, or ROR #0 would be RRX.
         sh_data = {{(WORD_W-8){1'b0}}, src_op2[IMM8_MSB:IMM8_LSB]};
         sh_amt  = {src_op2[ROT_MSB:ROT_LSB], 1'b0};
         sh_type = SH_ROR;
         if (src_op2[ROT_MSB:ROT_LSB] == 4'd0) begin
            res_op2   = sh_data;
            res_carry = src_c;
         end
      end else if (src_op2[REG_BIT]) begin
`ifdef OP2SEQ_REG_SHIFT_EN
         if (src_op2[ILLEG_BIT]) begin
            res_op2     = '0;
            res_carry   = src_c;
            res_illegal = 1'b1;
         end else begin
            sh_amt = amt[4:0];
            if (amt == 8'd0) begin
               res_op2   = src_rm;
               res_carry = src_c;
            end else if (amt[7:5] != 3'd0) begin
               // 32 and above cannot be expressed to the 5-bit shifter,
               // except ROR with a nonzero residue.
               unique case (sh_type)
                  SH_LSL: begin
                     res_op2   = '0;
                     res_carry = (amt == 8'd32) ? src_rm[0] : 1'b0;
                  end
                  SH_LSR: begin
                     res_op2   = '0;
                     res_carry = (amt == 8'd32) ? src_rm[WORD_W-1] : 1'b0;
                  end
                  SH_ASR: begin
                     res_op2   = {WORD_W{src_rm[WORD_W-1]}};
                     res_carry = src_rm[WORD_W-1];
                  end
                  SH_ROR: begin
                     if (amt[4:0] == 5'd0) begin
                        res_op2   = src_rm;
                        res_carry = src_rm[WORD_W-1];
                     end
                  end
                  default: ;
               endcase
            end
         end
`else
         // Register-specified shifts are not supported in this build.
         res_op2     = '0;
         res_carry   = src_c;
         res_illegal = 1'b1;
`endif
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d     = state_q;
      op2_d       = op2_q;
      carry_d     = carry_q;
      illegal_d   = illegal_q;
      out_Ready   = 1'b0;
      out_Valid   = 1'b0;
      out_Rs_req  = 1'b0;
      out_Rs_addr = 4'd0;

      unique case (state_q)
         ST_IDLE: begin
            out_Ready = 1'b1;
            if (in_Valid) begin
               if (take_rs_path) begin
                  state_d = ST_RS_REQ;
               end else begin
                  state_d   = ST_RESULT;
                  op2_d     = res_op2;
                  carry_d   = res_carry;
                  illegal_d = res_illegal;
               end
            end
         end
`ifdef OP2SEQ_REG_SHIFT_EN
         ST_RS_REQ: begin
            out_Rs_req  = 1'b1;
            out_Rs_addr = fld_q[RS_MSB:RS_LSB];
            state_d     = ST_RS_CAP;
         end
         ST_RS_CAP: begin
            state_d   = ST_RESULT;
            op2_d     = res_op2;
            carry_d   = res_carry;
            illegal_d = res_illegal;
         end
`endif
         ST_RESULT: begin
            out_Valid = 1'b1;
            if (in_Ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples pre-edge values regardless of block order.
      if (!in_Rst_N) begin
         state_q   <= ST_IDLE;
         op2_q     <= '0;
         carry_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op2_q     <= op2_d;
         carry_q   <= carry_d;
         illegal_q <= illegal_d;
      end
   end

   assign out_Op2     = op2_q;
   assign out_Carry   = carry_q;
   assign out_Illegal = illegal_q;

endmodule

// File: tb/tb_operand2_sequencer.sv
// -----------------------------------------------------------------------------
// tb_operand2_sequencer
//   Self-checking bench for operand2_sequencer. Expected results come from an
//   ARM shifter reference written with wide shifts, queued at accept and
//   compared when the DUT presents its result. Honours OP2SEQ_REG_SHIFT_EN.
// -----------------------------------------------------------------------------
module tb_operand2_sequencer;

`ifdef OP2SEQ_REG_SHIFT_EN
   localparam bit REG_EN = 1'b1;
`else
   localparam bit REG_EN = 1'b0;
`endif

   logic        in_Clk = 1'b0;
   logic        in_Rst_N = 1'b0;
   logic        in_Valid = 1'b0;
   logic        out_Ready;
   logic        in_I = 1'b0;
   logic [11:0] in_Operand2 = '0;
   logic [31:0] in_Rm_val = '0;
   logic        in_C_flag = 1'b0;
   logic        out_Rs_req;
   logic [3:0]  out_Rs_addr;
   logic [31:0] in_Rs_val = '0;
   logic        out_Valid;
   logic        in_Ready = 1'b0;
   logic [31:0] out_Op2;
   logic        out_Carry;
   logic        out_Illegal;

   operand2_sequencer dut (
      .in_Clk      (in_Clk),
      .in_Rst_N    (in_Rst_N),
      .in_Valid    (in_Valid),
      .out_Ready   (out_Ready),
      .in_I        (in_I),
      .in_Operand2 (in_Operand2),
      .in_Rm_val   (in_Rm_val),
      .in_C_flag   (in_C_flag),
      .out_Rs_req  (out_Rs_req),
      .out_Rs_addr (out_Rs_addr),
      .in_Rs_val   (in_Rs_val),
      .out_Valid   (out_Valid),
      .in_Ready    (in_Ready),
      .out_Op2     (out_Op2),
      .out_Carry   (out_Carry),
      .out_Illegal (out_Illegal)
   );

   always #5 in_Clk = ~in_Clk;

   typedef struct {
      logic [31:0] op2;
      logic        carry;
      logic        illegal;
      int          lat;
      int          pulses;
      logic [3:0]  addr;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // ARM operand-2 reference.
   function automatic exp_t model(input logic i, input logic [11:0] op, input logic [31:0] rm,
                                  input logic c, input logic [31:0] rs);
      exp_t                e;
      logic [63:0]         w;
      logic signed [63:0]  sw;
      logic [1:0]          t;
      int                  n;
      e.lat = 1; e.pulses = 0; e.addr = op[11:8];
      e.op2 = '0; e.carry = c; e.illegal = 1'b0;
      t = op[6:5];
      if (i) begin
         n = 2 * int'(op[11:8]);
         w = {24'h0, op[7:0], 24'h0, op[7:0]} >> n;
         e.op2   = w[31:0];
         e.carry = (n == 0) ? c : e.op2[31];
         return e;
      end
      if (op[4] && (op[7] || !REG_EN)) begin
         e.illegal = 1'b1;
         return e;
      end
      if (op[4]) begin
         n = int'(rs[7:0]);
         e.lat = 3; e.pulses = 1;
         if (n == 0) begin
            e.op2 = rm;
            return e;
         end
      end else begin
         n = int'(op[11:7]);
         if (n == 0) begin
            case (t)
               2'b00: begin e.op2 = rm; return e; end
               2'b11: begin e.op2 = {c, rm[31:1]}; e.carry = rm[0]; return e; end
               default: n = 32;
            endcase
         end
      end
      case (t)
         2'b00: begin w = {32'h0, rm} << n; e.op2 = w[31:0];  e.carry = w[32]; end
         2'b01: begin w = {rm, 32'h0} >> n; e.op2 = w[63:32]; e.carry = w[31]; end
         2'b10: begin
            sw = $signed({rm, 32'h0}) >>> ((n > 32) ? 32 : n);
            e.op2 = sw[63:32]; e.carry = sw[31];
         end
         default: begin
            n = n % 32;
            if (n == 0) begin
               e.op2 = rm; e.carry = rm[31];
            end else begin
               w = {rm, rm} >> n;
               e.op2 = w[31:0]; e.carry = e.op2[31];
            end
         end
      endcase
      return e;
   endfunction

   task automatic run_op(input logic i, input logic [11:0] op, input logic [31:0] rm,
                         input logic c, input logic [31:0] rs, input int hold);
      exp_t e;
      exp_t got;
      int   cyc;
      int   pulses;
      logic prev_req;
      e = model(i, op, rm, c, rs);
      @(posedge in_Clk); #1;
      in_Valid = 1'b1; in_I = i; in_Operand2 = op; in_Rm_val = rm; in_C_flag = c;
      in_Ready = 1'b0;
      check("ready_idle", out_Ready, 1);
      @(posedge in_Clk); #1;
      sb.push_back(e);
      // Inputs are don't-care after accept; scramble them.
      in_Valid = 1'b0; in_I = 1'($urandom); in_Operand2 = 12'($urandom);
      in_Rm_val = $urandom; in_C_flag = 1'($urandom);
      cyc = 1; pulses = 0; prev_req = 1'b0;
      while (out_Valid !== 1'b1 && cyc < 8) begin
         if (out_Rs_req === 1'b1) begin
            pulses++;
            check("rs_addr", out_Rs_addr, e.addr);
         end
         in_Rs_val = prev_req ? rs : $urandom;
         prev_req  = out_Rs_req;
         @(posedge in_Clk); #1;
         cyc++;
      end
      in_Rs_val = $urandom;
      check("valid_seen", out_Valid, 1);
      check("latency", cyc, e.lat);
      check("rs_pulses", pulses, e.pulses);
      check("rs_req_in_result", out_Rs_req, 0);
      got = sb.pop_front();
      check("op2", out_Op2, got.op2);
      check("carry", out_Carry, got.carry);
      check("illegal", out_Illegal, got.illegal);
      for (int k = 0; k < hold; k++) begin
         @(posedge in_Clk); #1;
         check("hold_valid", out_Valid, 1);
         check("hold_ready", out_Ready, 0);
         check("hold_op2", out_Op2, got.op2);
         check("hold_carry", out_Carry, got.carry);
      end
      in_Ready = 1'b1;
      @(posedge in_Clk); #1;
      in_Ready = 1'b0;
      check("valid_drop", out_Valid, 0);
      check("ready_back", out_Ready, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},   out_Valid, 0);
      check({tag, "_ready"},   out_Ready, 1);
      check({tag, "_rs_req"},  out_Rs_req, 0);
      check({tag, "_rs_addr"}, out_Rs_addr, 0);
      check({tag, "_op2"},     out_Op2, 0);
      check({tag, "_carry"},   out_Carry, 0);
      check({tag, "_illegal"}, out_Illegal, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      #1;
      check_reset_outputs("reset");
      @(posedge in_Clk); #1;
      in_Rst_N = 1'b1;

      // Immediate form.
      run_op(1'b1, 12'h4FF, 32'h1234_5678, 1'b0, 32'h0, 5);
      run_op(1'b1, 12'h0FF, 32'h0,         1'b1, 32'h0, 0);
      run_op(1'b1, 12'h0FF, 32'h0,         1'b0, 32'h0, 0);
      run_op(1'b1, 12'hF81, 32'h0,         1'b0, 32'h0, 1);
      // Immediate shift: LSR #0, RRX, LSL #0, ASR #0.
      run_op(1'b0, 12'h020, 32'h8000_0001, 1'b0, 32'h0, 0);
      run_op(1'b0, 12'h060, 32'h0000_0003, 1'b1, 32'h0, 0);
      run_op(1'b0, 12'h003, 32'hDEAD_BEEF, 1'b1, 32'h0, 0);
      run_op(1'b0, 12'h040, 32'h8000_0000, 1'b0, 32'h0, 0);
      // Register shifts (illegal path when not built).
      run_op(1'b0, 12'h310, 32'h0000_0003, 1'b0, 32'd32,  2);
      run_op(1'b0, 12'h310, 32'h0000_0003, 1'b1, 32'd33,  0);
      run_op(1'b0, 12'h270, 32'h8000_0000, 1'b0, 32'h40,  0);
      run_op(1'b0, 12'h270, 32'h8000_0000, 1'b0, 32'h100, 0);
      run_op(1'b0, 12'h270, 32'h8000_0000, 1'b0, 32'h24,  0);
      run_op(1'b0, 12'h530, 32'h8000_0001, 1'b0, 32'd32,  0);
      run_op(1'b0, 12'h550, 32'h9000_0000, 1'b0, 32'd200, 0);
      run_op(1'b0, 12'h110, 32'h0F00_0000, 1'b0, 32'd4,   0);
      // Illegal encoding.
      run_op(1'b0, 12'h090, 32'h1234_5678, 1'b1, 32'h0, 0);

      // Random mix of all forms.
      for (int k = 0; k < 24; k++) begin
         r = $urandom;
         run_op(r[12], r[11:0], $urandom, r[13], {24'h0, 8'($urandom_range(0, 70))},
                int'(r[15:14]));
      end

      // Reset in the cycle after accepting a register-shift request.
      @(posedge in_Clk); #1;
      in_Valid = 1'b1; in_I = 1'b0; in_Operand2 = 12'h310;
      in_Rm_val = 32'h3; in_C_flag = 1'b1;
      @(posedge in_Clk); #1;
      in_Valid = 1'b0;
      in_Rst_N = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(posedge in_Clk); #1;
      in_Rst_N = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge in_Clk); #1;
         check("no_result_after_reset", out_Valid, 0);
         check("rs_req_after_reset", out_Rs_req, 0);
      end

      // Normal operation resumes after reset.
      run_op(1'b1, 12'h4FF, 32'h0, 1'b0, 32'h0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
